mux2_rr_arbiter: RTL and testbench

//   Round-robin arbiter that shares one 2:1 mux output channel between two

---
 rtl/mux2_rr_arbiter_pkg.sv | 18 +
 rtl/mux2_rr_arbiter_if.sv | 28 ++
 rtl/mux2_rr_arbiter_mux2to1_w.sv | 11 +
 rtl/mux2_rr_arbiter.sv | 108 ++++++++++
 tb/tb_mux2_rr_arbiter.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/mux2_rr_arbiter_pkg.sv
// Shared types and encodings for the two-requester round-robin mux arbiter.
package mux2_rr_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GNT_A = 2'd1,
    ST_GNT_B = 2'd2
  } arb_state_t;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  // Burst counter must hold 0..max_burst-1 with one spare bit of headroom.
  function automatic int burst_cnt_w(input int max_burst);
    return $clog2(max_burst) + 1;
  endfunction

endpackage

// File: rtl/mux2_rr_arbiter_if.sv
// Channel bundle: two requesters in, one shared valid/ready stream out.
interface mux2_rr_arbiter_if #(
  parameter int DATA_W = 8
);
  // Handshake: a requester raises req_x with data_x and holds both stable
  // until its beat is transferred. Downstream, a beat moves on every rising
  // edge where out_valid & out_ready; out_valid never depends on out_ready.
  logic              req_a;
  logic [DATA_W-1:0] data_a;
  logic              req_b;
  logic [DATA_W-1:0] data_b;
  logic              gnt_a;
  logic              gnt_b;
  logic              sel;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport slave (
    input  req_a, data_a, req_b, data_b, out_ready,
    output gnt_a, gnt_b, sel, out_data, out_valid
  );

  modport master (
    output req_a, data_a, req_b, data_b, out_ready,
    input  gnt_a, gnt_b, sel, out_data, out_valid
  );
endinterface

// File: rtl/mux2_rr_arbiter_mux2to1_w.sv
// Plain W-bit 2:1 multiplexer: sel=0 picks a, sel=1 picks b.
module mux2to1_w #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sel,
  output logic [W-1:0] out
);
  assign out = sel ? b : a;
endmodule

// File: rtl/mux2_rr_arbiter.sv
// Round-robin arbiter sharing one output channel between requesters A and B,
// with a burst limit so a busy requester cannot starve the other.
module mux2_rr_arbiter
  import mux2_rr_arbiter_pkg::*;
#(
  parameter  int DATA_W    = 8,
  parameter  int MAX_BURST = 4,
  localparam int CNT_W     = burst_cnt_w(MAX_BURST)
) (
  input  logic             clk,
  input  logic             rst_n,
  mux2_rr_arbiter_if.slave bus,
  output arb_state_t       dbg_state,
  output logic [CNT_W-1:0] dbg_burst_cnt
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

  arb_state_t       state_q, state_d;
  logic             sel_q, sel_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             xfer;
  logic [DATA_W-1:0] mux_out;

  assign bus.gnt_a     = (state_q == ST_GNT_A);
  assign bus.gnt_b     = (state_q == ST_GNT_B);
  assign bus.sel       = sel_q;
  assign bus.out_valid = (bus.gnt_a & bus.req_a) | (bus.gnt_b & bus.req_b);
  assign bus.out_data  = mux_out;
  assign xfer          = bus.out_valid & bus.out_ready;
  assign dbg_state     = state_q;
  assign dbg_burst_cnt = cnt_q;

  mux2to1_w #(.W(DATA_W)) u_mux (
    .a   (bus.data_a),
    .b   (bus.data_b),
    .sel (sel_q),
    .out (mux_out)
  );

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        // On a tie, A wins unless A was the last side granted.
        if (bus.req_a && (!bus.req_b || last_q == SEL_B)) state_d = ST_GNT_A;
        else if (bus.req_b)                               state_d = ST_GNT_B;
      end
      ST_GNT_A: begin
        if (!bus.req_a) begin
          state_d = bus.req_b ? ST_GNT_B : ST_IDLE;
        end else if (xfer) begin
          if (cnt_q == CNT_LAST) begin
            if (bus.req_b) state_d = ST_GNT_B;
            else           cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_GNT_B: begin
        if (!bus.req_b) begin
          state_d = bus.req_a ? ST_GNT_A : ST_IDLE;
        end else if (xfer) begin
          if (cnt_q == CNT_LAST) begin
            if (bus.req_a) state_d = ST_GNT_A;
            else           cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Entry actions ride the same edge as the state change; sel is left
    // alone on the way to IDLE so the mux keeps its last choice.
    if (state_d != state_q) begin
      cnt_d = '0;
      if (state_d == ST_GNT_A) begin
        sel_d  = SEL_A;
        last_d = SEL_A;
      end else if (state_d == ST_GNT_B) begin
        sel_d  = SEL_B;
        last_d = SEL_B;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sel_q   <= SEL_A;
      last_q  <= SEL_B;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Bench for mux2_rr_arbiter: vector table, corner-case sequences, and
// randomized traffic against a grant/beat-counting reference model.
module tb_mux2_rr_arbiter;
  import mux2_rr_arbiter_pkg::*;

  localparam int DATA_W    = 8;
  localparam int MAX_BURST = 4;
  localparam int CNT_W     = $clog2(MAX_BURST) + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mux2_rr_arbiter_if #(.DATA_W(DATA_W)) bus ();
  arb_state_t       dbg_state;
  logic [CNT_W-1:0] dbg_burst_cnt;

  mux2_rr_arbiter #(.DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus.slave),
    .dbg_state     (dbg_state),
    .dbg_burst_cnt (dbg_burst_cnt)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [DATA_W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // owner: 0 none, 1 A, 2 B. beats counts every beat since the current grant.
  int m_owner, m_beats, m_last, m_xfer_side;
  logic m_sel;

  task automatic model_reset();
    m_owner = 0; m_beats = 0; m_last = 2; m_sel = 1'b0; m_xfer_side = 0;
  endtask

  task automatic model_grant(input int side);
    m_owner = side; m_beats = 0; m_last = side; m_sel = (side == 2);
  endtask

  task automatic model_step(input logic ra, input logic [7:0] da, input logic rb,
                            input logic [7:0] db, input logic rdy);
    logic own_req, oth_req;
    own_req = (m_owner == 1) ? ra : (m_owner == 2) ? rb : 1'b0;
    oth_req = (m_owner == 1) ? rb : ra;
    m_xfer_side = 0;
    if (m_owner == 0) begin
      if (ra && rb)  model_grant(m_last == 1 ? 2 : 1);
      else if (ra)   model_grant(1);
      else if (rb)   model_grant(2);
    end else if (!own_req) begin
      if (oth_req) model_grant(3 - m_owner);
      else         m_owner = 0;
    end else if (rdy) begin
      m_xfer_side = m_owner;
      exp_q.push_back(m_owner == 1 ? da : db);
      m_beats++;
      if ((m_beats % MAX_BURST) == 0 && oth_req) model_grant(3 - m_owner);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic ra, input logic [7:0] da, input logic rb,
                       input logic [7:0] db, input logic rdy);
    @(negedge clk);
    bus.req_a = ra; bus.data_a = da; bus.req_b = rb; bus.data_b = db;
    bus.out_ready = rdy;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.req_a = 1'b0; bus.req_b = 1'b0; bus.out_ready = 1'b0;
    bus.data_a = '0; bus.data_b = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic ra; logic [7:0] da; logic rb; logic [7:0] db; logic rdy;
    logic ga; logic gb; logic sel; logic vld; logic [7:0] data; logic [2:0] cnt;
  } vec_t;
  vec_t vecs[$];

  task automatic add_vec(input logic ra, input logic [7:0] da, input logic rb,
                         input logic [7:0] db, input logic rdy, input logic ga,
                         input logic gb, input logic sel, input logic vld,
                         input logic [7:0] data, input logic [2:0] cnt);
    vec_t v;
    v = '{ra, da, rb, db, rdy, ga, gb, sel, vld, data, cnt};
    vecs.push_back(v);
  endtask

  logic       ra, rb, rdy;
  logic [7:0] da, db;

  initial begin
    rst_n = 1'b1;
    bus.req_a = 1'b0; bus.req_b = 1'b0; bus.out_ready = 1'b0;
    bus.data_a = '0; bus.data_b = '0;

    // Reset with both requests held high: nothing granted.
    @(negedge clk);
    bus.req_a = 1'b1; bus.req_b = 1'b1; bus.out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_gnt_a", 32'(bus.gnt_a), 32'd0);
    chk("rst_gnt_b", 32'(bus.gnt_b), 32'd0);
    chk("rst_sel", 32'(bus.sel), 32'd0);
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));

    // Single requester, then a tie resolved against the last winner.
    add_vec(1'b1, 8'h5A, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h5A, 3'd0);
    add_vec(1'b1, 8'h5A, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h5A, 3'd0);
    add_vec(1'b0, 8'h5A, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h5A, 3'd1);
    add_vec(1'b0, 8'h5A, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h5A, 3'd0);
    add_vec(1'b1, 8'h11, 1'b1, 8'h22, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h11, 3'd0);
    add_vec(1'b1, 8'h11, 1'b1, 8'h22, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h22, 3'd0);
    add_vec(1'b1, 8'h11, 1'b1, 8'h23, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h23, 3'd1);
    add_vec(1'b1, 8'h11, 1'b1, 8'h24, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h24, 3'd2);
    add_vec(1'b1, 8'h11, 1'b1, 8'h25, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h25, 3'd3);
    add_vec(1'b1, 8'h12, 1'b1, 8'h26, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h12, 3'd0);
    add_vec(1'b1, 8'h13, 1'b1, 8'h26, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h13, 3'd1);
    add_vec(1'b1, 8'h14, 1'b1, 8'h26, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h14, 3'd2);
    add_vec(1'b1, 8'h15, 1'b1, 8'h26, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h15, 3'd3);
    add_vec(1'b1, 8'h16, 1'b1, 8'h26, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h26, 3'd0);

    do_reset();
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].ra, vecs[i].da, vecs[i].rb, vecs[i].db, vecs[i].rdy);
      chk($sformatf("vec%0d_gnt_a", i), 32'(bus.gnt_a), 32'(vecs[i].ga));
      chk($sformatf("vec%0d_gnt_b", i), 32'(bus.gnt_b), 32'(vecs[i].gb));
      chk($sformatf("vec%0d_sel", i), 32'(bus.sel), 32'(vecs[i].sel));
      chk($sformatf("vec%0d_valid", i), 32'(bus.out_valid), 32'(vecs[i].vld));
      chk($sformatf("vec%0d_data", i), 32'(bus.out_data), 32'(vecs[i].data));
      chk($sformatf("vec%0d_cnt", i), 32'(dbg_burst_cnt), 32'(vecs[i].cnt));
    end

    // Backpressure while B owns the channel freezes everything.
    do_reset();
    drive(1'b0, 8'h00, 1'b1, 8'hB0, 1'b1);
    drive(1'b0, 8'h00, 1'b1, 8'hB0, 1'b1);
    chk("bp_first_beat", 32'(bus.gnt_b & bus.out_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 8'h00, 1'b1, 8'hC3, 1'b0);
      chk($sformatf("bp%0d_gnt_b", i), 32'(bus.gnt_b), 32'd1);
      chk($sformatf("bp%0d_sel", i), 32'(bus.sel), 32'd1);
      chk($sformatf("bp%0d_cnt", i), 32'(dbg_burst_cnt), 32'd1);
      chk($sformatf("bp%0d_valid", i), 32'(bus.out_valid), 32'd1);
    end
    drive(1'b0, 8'h00, 1'b1, 8'hC3, 1'b1);
    chk("bp_release_data", 32'(bus.out_data), 32'hC3);
    chk("bp_release_cnt", 32'(dbg_burst_cnt), 32'd1);
    drive(1'b0, 8'h00, 1'b1, 8'hC4, 1'b1);
    chk("bp_after_cnt", 32'(dbg_burst_cnt), 32'd2);

    // Sole requester keeps the grant across burst wraps.
    do_reset();
    drive(1'b1, 8'h40, 1'b0, 8'h00, 1'b1);
    chk("sole_idle", 32'(bus.gnt_a), 32'd0);
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 8'(8'h41 + i), 1'b0, 8'h00, 1'b1);
      chk($sformatf("sole%0d_gnt_a", i), 32'(bus.gnt_a), 32'd1);
      chk($sformatf("sole%0d_valid", i), 32'(bus.out_valid), 32'd1);
      chk($sformatf("sole%0d_cnt", i), 32'(dbg_burst_cnt), 32'(i % MAX_BURST));
    end

    // Asynchronous reset between edges in the middle of an A burst.
    do_reset();
    drive(1'b1, 8'hA1, 1'b1, 8'hB1, 1'b1);
    drive(1'b1, 8'hA1, 1'b1, 8'hB1, 1'b1);
    drive(1'b1, 8'hA2, 1'b1, 8'hB1, 1'b1);
    chk("ar_pre_gnt_a", 32'(bus.gnt_a), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_gnt_a", 32'(bus.gnt_a), 32'd0);
    chk("ar_valid", 32'(bus.out_valid), 32'd0);
    chk("ar_state", 32'(dbg_state), 32'(ST_IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ar_rel_idle", 32'(bus.gnt_a | bus.gnt_b), 32'd0);
    drive(1'b1, 8'hA3, 1'b1, 8'hB3, 1'b1);
    chk("ar_tie_gnt_a", 32'(bus.gnt_a), 32'd1);
    chk("ar_tie_sel", 32'(bus.sel), 32'd0);

    // Randomized traffic against the reference model.
    do_reset();
    exp_q.delete();
    ra = 1'b0; rb = 1'b0; da = '0; db = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      rdy = ($urandom_range(0, 3) != 0);
      drive(ra, da, rb, db, rdy);
      chk("rnd_gnt_a", 32'(bus.gnt_a), 32'(m_owner == 1));
      chk("rnd_gnt_b", 32'(bus.gnt_b), 32'(m_owner == 2));
      chk("rnd_sel", 32'(bus.sel), 32'(m_sel));
      chk("rnd_valid", 32'(bus.out_valid),
          32'((m_owner == 1 && ra) || (m_owner == 2 && rb)));
      chk("rnd_cnt", 32'(dbg_burst_cnt), 32'(m_owner != 0 ? m_beats % MAX_BURST : 0));
      model_step(ra, da, rb, db, rdy);
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) chk("rnd_unexpected_beat", 32'(bus.out_data), 32'hFFFF_FFFF);
        else                   chk("rnd_beat_data", 32'(bus.out_data), 32'(exp_q.pop_front()));
      end
      // Requesters: hold until transferred, occasionally give up early.
      if (ra && m_xfer_side == 1)      begin ra = ($urandom_range(0, 9) < 7); da = 8'($urandom); end
      else if (!ra)                    begin ra = ($urandom_range(0, 1) == 1); da = 8'($urandom); end
      else if ($urandom_range(0, 19) == 0) ra = 1'b0;
      if (rb && m_xfer_side == 2)      begin rb = ($urandom_range(0, 9) < 7); db = 8'($urandom); end
      else if (!rb)                    begin rb = ($urandom_range(0, 1) == 1); db = 8'($urandom); end
      else if ($urandom_range(0, 19) == 0) rb = 1'b0;
    end
    chk("rnd_queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
